// File: rtl/pool_pkg.sv
// pool_pkg
//   Shared fixed-point types, FSM and phase enums, and default table
//   geometry. The circle renderer uses the same wall and radius constants.
//   Positions are unsigned Q11.6 (pos_t). Velocities are signed Q5.6 (vel_t).
//   near_pocket() is used only when BALL_MOTION_POCKET_EN is defined.
package pool_pkg;

  localparam int FRAC_BITS        = 6;
  localparam int DEF_LEFT_WALL    = 40;
  localparam int DEF_RIGHT_WALL   = 600;
  localparam int DEF_TOP_WALL     = 40;
  localparam int DEF_BOTTOM_WALL  = 440;
  localparam int DEF_RADIUS       = 16;
  localparam int DEF_POCKET_REACH = 20;

  typedef logic signed [11:0] vel_t;
  typedef logic [16:0]        pos_t;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_INTEGRATE,
    ST_COLLIDE,
    ST_FRICTION
  } motion_state_t;

  typedef enum logic [2:0] {
    PH_HOLD,
    PH_LOAD,
    PH_INTEGRATE,
    PH_COLLIDE,
    PH_FRICTION
  } axis_phase_t;

  // The integer part is read as signed, so a position that wrapped below
  // zero still measures as far from every pocket.
  // There are six pockets: the four corners plus the X-midpoints of the
  // top and bottom cushions.
  function automatic logic near_pocket(input pos_t x, input pos_t y,
                                       input int left, input int right,
                                       input int top, input int bottom,
                                       input int reach);
    int   ix, iy, px, py, dx, dy;
    logic hit;
    hit = 1'b0;
    ix  = int'($signed(x[16:6]));
    iy  = int'($signed(y[16:6]));
    for (int c = 0; c < 3; c++) begin
      px = (c == 0) ? left : ((c == 1) ? (left + right) / 2 : right);
      dx = (ix < px) ? px - ix : ix - px;
      for (int r = 0; r < 2; r++) begin
        py = (r == 0) ? top : bottom;
        dy = (iy < py) ? py - iy : iy - py;
        if (dx <= reach && dy <= reach) hit = 1'b1;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/ball_axis_step.sv
// ball_axis_step
//   Combinational next-state logic for one axis of ball motion.
//   The phase input selects which operation is applied:
//     HOLD      : pass position and velocity through unchanged
//     LOAD      : clamp hitVel to +/-MAX_SPEED and load it as velocity
//     INTEGRATE : pos + velocity (Q5.6 velocity sign-extended into Q11.6)
//     COLLIDE   : clamp position into [LOW_LIMIT, HIGH_LIMIT] and reflect
//                 the velocity
//     FRICTION  : move velocity toward zero by FRICTION
//   Ports:
//     phase      in  operation select
//     pos, vel   in  current position and velocity
//     hitVel     in  offered velocity, used in LOAD
//     posNext    out next position
//     velNext    out next velocity
//     reflected  out a cushion reflection happened (COLLIDE only)
module ball_axis_step
  import pool_pkg::*;
#(
  parameter int LOW_LIMIT  = 56,
  parameter int HIGH_LIMIT = 584,
  parameter int FRICTION   = 2,
  parameter int MAX_SPEED  = 1536
) (
  input  axis_phase_t phase,
  input  pos_t        pos,
  input  vel_t        vel,
  input  vel_t        hitVel,
  output pos_t        posNext,
  output vel_t        velNext,
  output logic        reflected
);

  localparam logic [10:0] LOW_INT  = 11'(LOW_LIMIT);
  localparam logic [10:0] HIGH_INT = 11'(HIGH_LIMIT);
  localparam pos_t        LOW_POS  = pos_t'(LOW_LIMIT * (1 << FRAC_BITS));
  localparam pos_t        HIGH_POS = pos_t'(HIGH_LIMIT * (1 << FRAC_BITS));
  localparam vel_t        FRIC     = vel_t'(FRICTION);
  localparam vel_t        MAXV     = vel_t'(MAX_SPEED);

  logic [17:0] sum;
  vel_t        velAbs;

  // Negating -2048 would overflow. That value never reaches here, because
  // every loaded velocity has already been clamped to +/-MAX_SPEED.
  assign velAbs = vel[11] ? -vel : vel;

  // Bit 16 of the 17-bit sum works as a sign bit. A legal position never
  // reaches 2^16, so bit 16 set means the integrate step went below zero.
  assign sum = {1'b0, pos} + {{6{vel[11]}}, vel};

  always_comb begin
    posNext   = pos;
    velNext   = vel;
    reflected = 1'b0;
    case (phase)
      PH_LOAD: begin
        if (hitVel > MAXV)       velNext = MAXV;
        else if (hitVel < -MAXV) velNext = -MAXV;
        else                     velNext = hitVel;
      end
      PH_INTEGRATE: posNext = sum[16:0];
      PH_COLLIDE: begin
        if (pos[16] || pos[16:6] < LOW_INT) begin
          posNext   = LOW_POS;
          velNext   = velAbs;
          reflected = 1'b1;
        end else if (pos[16:6] > HIGH_INT) begin
          posNext   = HIGH_POS;
          velNext   = -velAbs;
          reflected = 1'b1;
        end
      end
      PH_FRICTION: begin
        if (velAbs <= FRIC) velNext = '0;
        else if (vel[11])   velNext = vel + FRIC;
        else                velNext = vel - FRIC;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl
//   Produces the ball centre for the circle renderer. On each
//   startOfFrame pulse it steps through INTEGRATE, COLLIDE and FRICTION,
//   then returns to WAIT. In WAIT it accepts new velocities through a
//   valid/ready handshake.
//   Optional pocket feature: define BALL_MOTION_POCKET_EN.
//   Ports:
//     clk, resetN        clock, async active-low reset
//     startOfFrame       one-cycle pulse per video frame
//     hitValid/hitReady  velocity handshake; hitVx/hitVy are Q5.6 signed
//     respawn            return the ball to INIT (pocket build only)
//     centerX/centerY    integer ball centre
//     moving             either velocity component is non-zero
//     bounce             one-cycle pulse after a frame that hit a cushion
//     pocketed           ball is sitting in a pocket (pocket build only)
module ball_motion_ctrl
  import pool_pkg::*;
#(
  parameter int INIT_X      = 320,
  parameter int INIT_Y      = 240,
  parameter int LEFT_WALL   = DEF_LEFT_WALL,
  parameter int RIGHT_WALL  = DEF_RIGHT_WALL,
  parameter int TOP_WALL    = DEF_TOP_WALL,
  parameter int BOTTOM_WALL = DEF_BOTTOM_WALL,
  parameter int RADIUS      = DEF_RADIUS,
  parameter int FRICTION    = 2,
  parameter int MAX_SPEED   = 1536
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               hitValid,
  input  logic signed [11:0] hitVx,
  input  logic signed [11:0] hitVy,
  output logic               hitReady,
  input  logic               respawn,
  output logic        [10:0] centerX,
  output logic        [10:0] centerY,
  output logic               moving,
  output logic               bounce,
  output logic               pocketed
);

  localparam pos_t INIT_POS_X = pos_t'(INIT_X * (1 << FRAC_BITS));
  localparam pos_t INIT_POS_Y = pos_t'(INIT_Y * (1 << FRAC_BITS));

  motion_state_t state, stateNext;
  axis_phase_t   phase;
  pos_t          posX, posY, posXNext, posYNext;
  vel_t          velX, velY, velXNext, velYNext;
  logic          reflX, reflY, frameReflected, hitFire;

`ifdef BALL_MOTION_POCKET_EN
  logic pocketedReg, atPocket;
  assign atPocket = near_pocket(posX, posY, LEFT_WALL, RIGHT_WALL, TOP_WALL,
                                BOTTOM_WALL, DEF_POCKET_REACH);
  assign pocketed = pocketedReg;
`else
  logic unusedRespawn;
  assign unusedRespawn = respawn;
  assign pocketed      = 1'b0;
`endif

  assign hitFire = hitValid && hitReady;

  ball_axis_step #(
    .LOW_LIMIT (LEFT_WALL + RADIUS),
    .HIGH_LIMIT(RIGHT_WALL - RADIUS),
    .FRICTION  (FRICTION),
    .MAX_SPEED (MAX_SPEED)
  ) u_axis_x (
    .phase    (phase),
    .pos      (posX),
    .vel      (velX),
    .hitVel   (hitVx),
    .posNext  (posXNext),
    .velNext  (velXNext),
    .reflected(reflX)
  );

  ball_axis_step #(
    .LOW_LIMIT (TOP_WALL + RADIUS),
    .HIGH_LIMIT(BOTTOM_WALL - RADIUS),
    .FRICTION  (FRICTION),
    .MAX_SPEED (MAX_SPEED)
  ) u_axis_y (
    .phase    (phase),
    .pos      (posY),
    .vel      (velY),
    .hitVel   (hitVy),
    .posNext  (posYNext),
    .velNext  (velYNext),
    .reflected(reflY)
  );

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= ST_WAIT;
    else         state <= stateNext;
  end

  // Next state: each frame step takes one cycle. A pocketed ball, or a
  // respawn request, keeps the FSM in WAIT.
  always_comb begin
    stateNext = state;
    case (state)
      ST_WAIT: begin
        if (startOfFrame) stateNext = ST_INTEGRATE;
`ifdef BALL_MOTION_POCKET_EN
        if (pocketedReg || respawn) stateNext = ST_WAIT;
`endif
      end
      ST_INTEGRATE: stateNext = ST_COLLIDE;
      ST_COLLIDE:   stateNext = ST_FRICTION;
      ST_FRICTION:  stateNext = ST_WAIT;
      default:      stateNext = ST_WAIT;
    endcase
  end

  // Outputs: the axis phase, and hitReady. A frame start in the same cycle
  // as a hit takes priority, so hitReady drops and the hit waits.
  always_comb begin
    hitReady = (state == ST_WAIT) && !startOfFrame;
`ifdef BALL_MOTION_POCKET_EN
    if (pocketedReg || respawn) hitReady = 1'b0;
`endif
    phase = PH_HOLD;
    case (state)
      ST_WAIT:      if (hitFire) phase = PH_LOAD;
      ST_INTEGRATE: phase = PH_INTEGRATE;
      ST_COLLIDE:   phase = PH_COLLIDE;
      ST_FRICTION:  phase = PH_FRICTION;
      default:      phase = PH_HOLD;
    endcase
  end

  // Datapath: the axis steppers compute every update. This block decides
  // when the visible outputs (centre, moving, bounce) are published.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      posX           <= INIT_POS_X;
      posY           <= INIT_POS_Y;
      velX           <= '0;
      velY           <= '0;
      centerX        <= 11'(INIT_X);
      centerY        <= 11'(INIT_Y);
      moving         <= 1'b0;
      bounce         <= 1'b0;
      frameReflected <= 1'b0;
`ifdef BALL_MOTION_POCKET_EN
      pocketedReg    <= 1'b0;
`endif
    end else begin
      bounce <= 1'b0;
      posX   <= posXNext;
      posY   <= posYNext;
      velX   <= velXNext;
      velY   <= velYNext;
      case (state)
        ST_WAIT: if (hitFire) moving <= (velXNext != '0) || (velYNext != '0);
        ST_COLLIDE: frameReflected <= reflX | reflY;
        ST_FRICTION: begin
          centerX <= posX[16:6];
          centerY <= posY[16:6];
          bounce  <= frameReflected;
          moving  <= (velXNext != '0) || (velYNext != '0);
        end
        default: ;
      endcase
`ifdef BALL_MOTION_POCKET_EN
      // The pocket check takes priority over reflection. The ball stays at
      // its post-integrate position and stops.
      if (state == ST_COLLIDE && atPocket) begin
        posX           <= posX;
        posY           <= posY;
        velX           <= '0;
        velY           <= '0;
        frameReflected <= 1'b0;
        pocketedReg    <= 1'b1;
      end
      if (state == ST_WAIT && respawn) begin
        posX        <= INIT_POS_X;
        posY        <= INIT_POS_Y;
        velX        <= '0;
        velY        <= '0;
        centerX     <= 11'(INIT_X);
        centerY     <= 11'(INIT_Y);
        moving      <= 1'b0;
        pocketedReg <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// tb_ball_motion_ctrl
//   Directed testbench for ball_motion_ctrl. Each scenario task drives its
//   own stimulus and compares against hand-computed centre positions.
//   Velocities are observed indirectly, through the position change on
//   later frames. Define BALL_MOTION_POCKET_EN to run the pocket scenario.
module tb_ball_motion_ctrl;

  logic               clk;
  logic               resetN;
  logic               startOfFrame;
  logic               hitValid;
  logic signed [11:0] hitVx;
  logic signed [11:0] hitVy;
  logic               hitReady;
  logic               respawn;
  logic        [10:0] centerX;
  logic        [10:0] centerY;
  logic               moving;
  logic               bounce;
  logic               pocketed;

  int checks = 0;
  int passes = 0;

  ball_motion_ctrl dut (
    .clk         (clk),
    .resetN      (resetN),
    .startOfFrame(startOfFrame),
    .hitValid    (hitValid),
    .hitVx       (hitVx),
    .hitVy       (hitVy),
    .hitReady    (hitReady),
    .respawn     (respawn),
    .centerX     (centerX),
    .centerY     (centerY),
    .moving      (moving),
    .bounce      (bounce),
    .pocketed    (pocketed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Leaves the bench at a negedge with reset released and inputs idle.
  task automatic do_reset;
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    hitValid     = 1'b0;
    hitVx        = '0;
    hitVy        = '0;
    respawn      = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
  endtask

  // Offers a velocity and holds it until it is accepted (bounded wait).
  task automatic send_hit(input int vx, input int vy);
    int n;
    n        = 0;
    hitValid = 1'b1;
    hitVx    = 12'(vx);
    hitVy    = 12'(vy);
    #1;
    while (!hitReady && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (!hitReady) $display("[TB] FAIL hit_accept: hitReady stayed %0b, wanted 1", hitReady);
    else passes++;
    @(negedge clk);
    hitValid = 1'b0;
  endtask

  // Pulses startOfFrame and returns at the negedge just after the centre
  // update.
  task automatic run_frame;
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (centerX !== 11'd320) $display("[TB] FAIL reset_centerX: got %0d want 320", centerX); else passes++;
    checks++; if (centerY !== 11'd240) $display("[TB] FAIL reset_centerY: got %0d want 240", centerY); else passes++;
    checks++; if (moving !== 1'b0) $display("[TB] FAIL reset_moving: got %0b want 0", moving); else passes++;
    checks++; if (hitReady !== 1'b1) $display("[TB] FAIL reset_hitReady: got %0b want 1", hitReady); else passes++;
    checks++; if (bounce !== 1'b0) $display("[TB] FAIL reset_bounce: got %0b want 0", bounce); else passes++;
    checks++; if (pocketed !== 1'b0) $display("[TB] FAIL reset_pocketed: got %0b want 0", pocketed); else passes++;
  endtask

  // A hit of +640 moves the ball 10 px and friction leaves 638. The second
  // frame then lands on 21120 + 638 = 21758, which is 339 px.
  task automatic test_integrate;
    do_reset();
    send_hit(640, 0);
    checks++; if (moving !== 1'b1) $display("[TB] FAIL hit_moving: got %0b want 1", moving); else passes++;
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (centerX !== 11'd320) $display("[TB] FAIL latency_early: got %0d want 320", centerX); else passes++;
    @(negedge clk);
    checks++; if (centerX !== 11'd330) $display("[TB] FAIL integrate_x: got %0d want 330", centerX); else passes++;
    checks++; if (centerY !== 11'd240) $display("[TB] FAIL integrate_y: got %0d want 240", centerY); else passes++;
    checks++; if (bounce !== 1'b0) $display("[TB] FAIL no_bounce: got %0b want 0", bounce); else passes++;
    run_frame();
    checks++; if (centerX !== 11'd339) $display("[TB] FAIL friction_638: got %0d want 339", centerX); else passes++;
  endtask

  // 10 x 24 px gives 560. Adding 20 px gives 580. Then +10 px overshoots to
  // 590, which clamps to 584 and reflects, so the next frame moves left to
  // 574.
  task automatic test_right_bounce;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      send_hit(1536, 0);
      run_frame();
    end
    checks++; if (centerX !== 11'd560) $display("[TB] FAIL run_to_560: got %0d want 560", centerX); else passes++;
    send_hit(1280, 0);
    run_frame();
    checks++; if (centerX !== 11'd580) $display("[TB] FAIL run_to_580: got %0d want 580", centerX); else passes++;
    send_hit(640, 0);
    run_frame();
    checks++; if (centerX !== 11'd584) $display("[TB] FAIL right_clamp: got %0d want 584", centerX); else passes++;
    checks++; if (bounce !== 1'b1) $display("[TB] FAIL bounce_pulse: got %0b want 1", bounce); else passes++;
    @(negedge clk);
    checks++; if (bounce !== 1'b0) $display("[TB] FAIL bounce_one_cycle: got %0b want 0", bounce); else passes++;
    run_frame();
    checks++; if (centerX !== 11'd574) $display("[TB] FAIL right_reflect: got %0d want 574", centerX); else passes++;
  endtask

  // Bottom wall: after 8 frames y = 240 + 192 = 432, which exceeds 424 and
  // clamps. Left wall: 11 frames land exactly on 56 (no bounce). A 12th
  // frame reaches 32, which clamps to 56 and reflects. On the following
  // frame the reflected 1534 carries the ball to 79.
  task automatic test_walls;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send_hit(-1536, 1536);
      run_frame();
    end
    checks++; if (centerX !== 11'd128) $display("[TB] FAIL diag_x: got %0d want 128", centerX); else passes++;
    checks++; if (centerY !== 11'd424) $display("[TB] FAIL bottom_clamp: got %0d want 424", centerY); else passes++;
    checks++; if (bounce !== 1'b1) $display("[TB] FAIL bottom_bounce: got %0b want 1", bounce); else passes++;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      send_hit(-1536, 0);
      run_frame();
    end
    checks++; if (centerX !== 11'd56) $display("[TB] FAIL left_exact: got %0d want 56", centerX); else passes++;
    checks++; if (bounce !== 1'b0) $display("[TB] FAIL left_exact_nobounce: got %0b want 0", bounce); else passes++;
    send_hit(-1536, 0);
    run_frame();
    checks++; if (centerX !== 11'd56) $display("[TB] FAIL left_clamp: got %0d want 56", centerX); else passes++;
    checks++; if (bounce !== 1'b1) $display("[TB] FAIL left_bounce: got %0b want 1", bounce); else passes++;
    run_frame();
    checks++; if (centerX !== 11'd79) $display("[TB] FAIL left_reflect: got %0d want 79", centerX); else passes++;
  endtask

  // The hit is offered in the same cycle as startOfFrame, so it must wait
  // for the frame to finish. The frame therefore runs with zero velocity.
  // 2000 clamps to 1536 and -2048 clamps to -1536 (24 px each way).
  task automatic test_clamp_and_collision;
    int n;
    do_reset();
    startOfFrame = 1'b1;
    hitValid     = 1'b1;
    hitVx        = 12'sd2000;
    hitVy        = -12'sd2048;
    #1;
    checks++; if (hitReady !== 1'b0) $display("[TB] FAIL sof_blocks_hit: got %0b want 0", hitReady); else passes++;
    @(negedge clk);
    startOfFrame = 1'b0;
    #1;
    checks++; if (hitReady !== 1'b0) $display("[TB] FAIL busy_not_ready: got %0b want 0", hitReady); else passes++;
    n = 0;
    while (!hitReady && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++; if (n !== 3) $display("[TB] FAIL hit_wait_cycles: got %0d want 3", n); else passes++;
    checks++; if (centerX !== 11'd320) $display("[TB] FAIL frame_before_hit: got %0d want 320", centerX); else passes++;
    @(negedge clk);
    hitValid = 1'b0;
    checks++; if (moving !== 1'b1) $display("[TB] FAIL late_hit_moving: got %0b want 1", moving); else passes++;
    run_frame();
    checks++; if (centerX !== 11'd344) $display("[TB] FAIL clamp_pos: got %0d want 344", centerX); else passes++;
    checks++; if (centerY !== 11'd216) $display("[TB] FAIL clamp_neg: got %0d want 216", centerY); else passes++;
  endtask

  // vx=+3: the first frame leaves velocity 1 (still moving). The second
  // frame leaves 0 (stopped).
  task automatic test_friction;
    do_reset();
    send_hit(3, 0);
    run_frame();
    checks++; if (moving !== 1'b1) $display("[TB] FAIL friction_moving1: got %0b want 1", moving); else passes++;
    checks++; if (centerX !== 11'd320) $display("[TB] FAIL friction_pos1: got %0d want 320", centerX); else passes++;
    run_frame();
    checks++; if (moving !== 1'b0) $display("[TB] FAIL friction_stop: got %0b want 0", moving); else passes++;
  endtask

  task automatic test_midframe_reset;
    do_reset();
    send_hit(640, 640);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    @(negedge clk);
    resetN = 1'b0;
    #1;
    checks++; if (centerX !== 11'd320) $display("[TB] FAIL midreset_x: got %0d want 320", centerX); else passes++;
    checks++; if (moving !== 1'b0) $display("[TB] FAIL midreset_moving: got %0b want 0", moving); else passes++;
    checks++; if (hitReady !== 1'b1) $display("[TB] FAIL midreset_ready: got %0b want 1", hitReady); else passes++;
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    run_frame();
    checks++; if (centerY !== 11'd240) $display("[TB] FAIL midreset_vel_cleared: got %0d want 240", centerY); else passes++;
  endtask

`ifdef BALL_MOTION_POCKET_EN
  // Re-hitting every frame keeps the step exact: x = 20480 - 1400n and
  // y = 15360 - 1000n. Frame 12 is the first with both within 20 px of
  // (40,40), giving centre (57,52).
  task automatic test_pocket;
    int hitFrame;
    do_reset();
    hitFrame = 0;
    for (int n = 1; n <= 20 && hitFrame == 0; n++) begin
      send_hit(-1400, -1000);
      run_frame();
      if (pocketed) hitFrame = n;
    end
    checks++; if (hitFrame !== 12) $display("[TB] FAIL pocket_frame: got %0d want 12", hitFrame); else passes++;
    checks++; if (centerX !== 11'd57) $display("[TB] FAIL pocket_x: got %0d want 57", centerX); else passes++;
    checks++; if (centerY !== 11'd52) $display("[TB] FAIL pocket_y: got %0d want 52", centerY); else passes++;
    checks++; if (hitReady !== 1'b0) $display("[TB] FAIL pocket_ready: got %0b want 0", hitReady); else passes++;
    run_frame();
    checks++; if (centerX !== 11'd57) $display("[TB] FAIL pocket_frame_ignored: got %0d want 57", centerX); else passes++;
    respawn = 1'b1;
    @(negedge clk);
    respawn = 1'b0;
    #1;
    checks++; if (centerX !== 11'd320) $display("[TB] FAIL respawn_x: got %0d want 320", centerX); else passes++;
    checks++; if (centerY !== 11'd240) $display("[TB] FAIL respawn_y: got %0d want 240", centerY); else passes++;
    checks++; if (pocketed !== 1'b0) $display("[TB] FAIL respawn_pocketed: got %0b want 0", pocketed); else passes++;
    checks++; if (hitReady !== 1'b1) $display("[TB] FAIL respawn_ready: got %0b want 1", hitReady); else passes++;
  endtask
`else
  task automatic test_pocket;
    do_reset();
    send_hit(640, 0);
    run_frame();
    respawn = 1'b1;
    @(negedge clk);
    respawn = 1'b0;
    #1;
    checks++; if (centerX !== 11'd330) $display("[TB] FAIL respawn_ignored: got %0d want 330", centerX); else passes++;
    checks++; if (pocketed !== 1'b0) $display("[TB] FAIL pocketed_const: got %0b want 0", pocketed); else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_integrate();
    test_right_bounce();
    test_walls();
    test_clamp_and_collision();
    test_friction();
    test_midframe_reset();
    test_pocket();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
